multicore_mem_arbiter: RTL and testbench
========================================

# multicore_mem_arbiter

N-core shared-memory arbiter for the multicore top. It replaces the fixed two-cache memory path with a parametrised round-robin arbiter that serialises cache requests onto the single RAM port. It also generalises the two-core halt AND into a sticky N-core halt aggregator. It sits between the per-core caches and the RAM port in the multicore top.

## Interface
- NCORES, 2, number of requesting caches (1..8)
- ADDR_W, 32, address width
- DATA_W, 32, data width
- WDOG_MAX, 255, watchdog limit in cycles; only used with the macro in Configuration
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- req_ren  in  NCORES  per-core read request
- req_wen  in  NCORES  per-core write request
- req_addr  in  NCORES*ADDR_W  per-core address; core i at bits [i*ADDR_W +: ADDR_W]
- req_store  in  NCORES*DATA_W  per-core write data, packed the same way
- req_load  out  DATA_W  read data, broadcast to all cores
- req_wait  out  NCORES  per-core stall; low only in the completing cycle
- flushed  in  NCORES  per-core flush-complete
- halt  out  1  all cores have flushed
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  DATA_W  RAM write data
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramload  in  DATA_W  RAM read data
- ramstate  in  2  RAM status: FREE, BUSY, ACCESS, ERROR
- arb_timeout  out  1  sticky watchdog flag; tied 0 when the watchdog is compiled out

## Operation
- FSM states: IDLE and XFER. Registers: grant index gnt, round-robin pointer rr_ptr.
- IDLE: a core is requesting when req_ren|req_wen is high. The arbiter picks the first requesting core at or after rr_ptr, wrapping modulo NCORES, latches it into gnt and moves to XFER. With no requests it stays in IDLE.
- XFER: the RAM port is driven from core gnt.
  - If req_wen[gnt] is high, ramWEN=1 and ramREN=0. Write wins when both are high.
  - Otherwise ramREN=1.
  - ramaddr and ramstore come from core gnt.
- IDLE outputs: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- Completion: in XFER with ramstate==ACCESS, req_wait[gnt]=0 for that cycle. Next state is IDLE and rr_ptr becomes (gnt+1) mod NCORES.
- BUSY, FREE and ERROR in XFER: the arbiter holds in XFER, and a request seeing ERROR is retried. All req_wait bits other than one completing core are 1 in every cycle.
- Abort: if core gnt drops both req_ren and req_wen while in XFER, the arbiter returns to IDLE next cycle, rr_ptr is unchanged and no wait bit is released.
- req_load = ramload, combinational, in all states.
- Halt: a sticky bit done[i] is set when flushed[i]=1 and cleared only by RST. halt is a register equal to &done, so it rises 1 cycle after the last flush.
- NCORES=1: the pointer is constant 0 and the block acts as a pass-through with the FSM.

## Timing
- Reset values (one edge with RST=1): state=IDLE, gnt=0, rr_ptr=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, req_wait all 1, halt=0, arb_timeout=0, done=0.
- Request high in cycle t while in IDLE: RAM signals are valid in cycle t+1.
- Best case is ACCESS in cycle t+1, giving a completion latency of 2 cycles.
- One IDLE bubble cycle separates back-to-back grants.
- Reset during XFER: ramREN and ramWEN are 0 in the cycle after the reset edge. The in-flight access is dropped.
- Simultaneous completion and a new request from the same core: the new request is handled in the next IDLE pass under the rotated pointer.

## Configuration
- MC_ARB_WATCHDOG_EN defined:
  - A cycle counter, WDOG_MAX-wide enough, counts cycles in XFER and clears on entry to XFER.
  - When the count reaches WDOG_MAX without ACCESS, arb_timeout is set sticky, the arbiter aborts to IDLE and rr_ptr advances past gnt.
- Macro undefined: no counter exists, arb_timeout is constant 0 and XFER waits indefinitely.

## Structure
- Package multicore_pkg holds:
  - ramstate_t enum (FREE, BUSY, ACCESS, ERROR)
  - arb_state_t (IDLE, XFER)
  - NCORES_MAX=8
- Sub-module rr_priority_pick: combinational round-robin finder. Inputs are the request vector and pointer; outputs are the index and a valid bit.

## Test plan
- Reset, then core 0 reads 0x40 with ACCESS on the second cycle → ramREN=1, ramaddr=0x40, req_wait[0]=0 in cycle t+1, req_load=ramload, rr_ptr=1.
- NCORES=4, all cores requesting continuously with ACCESS after 1 BUSY cycle → grant order 0,1,2,3,0, one IDLE bubble between grants, no starvation.
- Core 2 asserts both REN and WEN with addr 0x80 and store 0xDEADBEEF → ramWEN=1, ramREN=0, ramstore=0xDEADBEEF.
- Core 1 granted and RST pulsed mid-BUSY → next cycle ramREN=ramWEN=0 and all req_wait=1; after reset a core-0 request is granted first.
- flushed pulsed for cores 0, 2, 1, 3 in separate cycles (NCORES=4) → halt stays 0 until 1 cycle after core 3's pulse, then stays 1.
- MC_ARB_WATCHDOG_EN, WDOG_MAX=16, ramstate held BUSY → arb_timeout=1 after 16 XFER cycles, state returns to IDLE, and the next grant goes to the next requester.

Source files
------------

// File: rtl/multicore_pkg.sv
// Shared types for the multicore memory arbiter: RAM status codes, arbiter states
// and the upper bound on the number of requesting cores.
package multicore_pkg;

  localparam int unsigned NCORES_MAX = 8;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin finder: returns the first requester at or after ptr,
// wrapping modulo N, plus a valid bit when any request is present.
module rr_priority_pick #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = 1
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic [IdxW-1:0] idx,
  output logic            valid
);

  int unsigned     sum;
  logic [IdxW-1:0] cand;

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    sum   = 0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      // ptr is always below N, so a single subtraction implements the wrap.
      sum = 32'(ptr) + i;
      if (sum >= N) begin
        sum = sum - N;
      end
      cand = sum[IdxW-1:0];
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/multicore_mem_arbiter.sv
// N-core round-robin arbiter serialising cache requests onto one RAM port, with a
// sticky N-core halt aggregator. Optional XFER watchdog: define MC_ARB_WATCHDOG_EN.
module multicore_mem_arbiter
  import multicore_pkg::*;
#(
  parameter int unsigned NCORES   = 2,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned WDOG_MAX = 255
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NCORES-1:0]        req_ren,
  input  logic [NCORES-1:0]        req_wen,
  input  logic [NCORES*ADDR_W-1:0] req_addr,
  input  logic [NCORES*DATA_W-1:0] req_store,
  output logic [DATA_W-1:0]        req_load,
  output logic [NCORES-1:0]        req_wait,
  input  logic [NCORES-1:0]        flushed,
  output logic                     halt,
  output logic [ADDR_W-1:0]        ramaddr,
  output logic [DATA_W-1:0]        ramstore,
  output logic                     ramREN,
  output logic                     ramWEN,
  input  logic [DATA_W-1:0]        ramload,
  input  logic [1:0]               ramstate,
  output logic                     arb_timeout
);

  localparam int unsigned IdxW = (NCORES > 1) ? $clog2(NCORES) : 1;

  if (NCORES < 1 || NCORES > NCORES_MAX || WDOG_MAX < 1) begin : g_param_err
    $error("multicore_mem_arbiter: NCORES must be 1..8 and WDOG_MAX at least 1");
  end

  arb_state_t      state_q;
  logic [IdxW-1:0] gnt_q;
  logic [IdxW-1:0] rr_ptr_q;
  logic [NCORES-1:0] done_q;
  logic            halt_q;

  logic [ADDR_W-1:0] addr_arr  [NCORES];
  logic [DATA_W-1:0] store_arr [NCORES];

  for (genvar i = 0; i < NCORES; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign store_arr[i] = req_store[i*DATA_W +: DATA_W];
  end

  logic [NCORES-1:0] req_any;
  logic [IdxW-1:0]   pick_idx;
  logic              pick_valid;

  assign req_any = req_ren | req_wen;

  rr_priority_pick #(
    .N    (NCORES),
    .IdxW (IdxW)
  ) u_pick (
    .req   (req_any),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  ramstate_t       ram_st;
  logic            in_xfer;
  logic            gnt_wen;
  logic            gnt_active;
  logic            xfer_live;
  logic            complete;
  logic            abort;
  logic            wdog_hit;
  logic [IdxW-1:0] ptr_next;

  assign ram_st     = ramstate_t'(ramstate);
  assign in_xfer    = (state_q == XFER);
  assign gnt_wen    = req_wen[gnt_q];
  assign gnt_active = req_ren[gnt_q] | req_wen[gnt_q];
  assign xfer_live  = in_xfer && gnt_active;
  assign complete   = xfer_live && (ram_st == ACCESS);
  assign abort      = in_xfer && !gnt_active;
  assign ptr_next   = (gnt_q == IdxW'(NCORES - 1)) ? '0 : gnt_q + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      gnt_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            gnt_q   <= pick_idx;
            state_q <= XFER;
          end
        end
        XFER: begin
          // A dropped request leaves the pointer alone; completion and timeout rotate it.
          if (abort) begin
            state_q <= IDLE;
          end else if (complete || wdog_hit) begin
            state_q  <= IDLE;
            rr_ptr_q <= ptr_next;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    if (in_xfer) begin
      ramWEN   = gnt_wen;
      ramREN   = !gnt_wen;
      ramaddr  = addr_arr[gnt_q];
      ramstore = store_arr[gnt_q];
    end
  end

  always_comb begin
    req_wait = '1;
    for (int unsigned i = 0; i < NCORES; i++) begin
      req_wait[i] = !(complete && (gnt_q == IdxW'(i)));
    end
  end

  assign req_load = ramload;

  // halt registers the post-update done set so it rises the cycle after the last flush.
  always_ff @(posedge CLK) begin
    if (RST) begin
      done_q <= '0;
      halt_q <= 1'b0;
    end else begin
      done_q <= done_q | flushed;
      halt_q <= &(done_q | flushed);
    end
  end

  assign halt = halt_q;

`ifdef MC_ARB_WATCHDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_MAX + 1);

  logic [WdogW-1:0] wdog_q;
  logic             timeout_q;

  assign wdog_hit = xfer_live && (ram_st != ACCESS) && (wdog_q == WdogW'(WDOG_MAX - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      // Held at zero while idle so every XFER entry starts a fresh count.
      if (state_q == IDLE) begin
        wdog_q <= '0;
      end else begin
        wdog_q <= wdog_q + 1'b1;
      end
      if (wdog_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign arb_timeout = timeout_q;
`else
  assign wdog_hit    = 1'b0;
  assign arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_multicore_mem_arbiter.sv
// Bench for multicore_mem_arbiter (NCORES=4): directed vectors with literal checks
// plus a per-cycle transaction-level model compared on every falling edge.
module tb_multicore_mem_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WD = 16;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;

`ifdef MC_ARB_WATCHDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    ren = '0;
  logic [N-1:0]    wen = '0;
  logic [N-1:0]    flushed = '0;
  logic [AW-1:0]   addr [N];
  logic [DW-1:0]   store [N];
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_store;
  logic [DW-1:0]   req_load;
  logic [DW-1:0]   ramload = '0;
  logic [N-1:0]    req_wait;
  logic            halt;
  logic [AW-1:0]   ramaddr;
  logic [DW-1:0]   ramstore;
  logic            ram_ren;
  logic            ram_wen;
  logic [1:0]      rs = RS_FREE;
  logic            arb_timeout;

  always #5 clk = ~clk;

  always_comb begin
    req_addr  = '0;
    req_store = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = addr[i];
      req_store[i*DW +: DW] = store[i];
    end
  end

  multicore_mem_arbiter #(
    .NCORES   (N),
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .WDOG_MAX (WD)
  ) dut (
    .CLK         (clk),
    .RST         (rst),
    .req_ren     (ren),
    .req_wen     (wen),
    .req_addr    (req_addr),
    .req_store   (req_store),
    .req_load    (req_load),
    .req_wait    (req_wait),
    .flushed     (flushed),
    .halt        (halt),
    .ramaddr     (ramaddr),
    .ramstore    (ramstore),
    .ramREN      (ram_ren),
    .ramWEN      (ram_wen),
    .ramload     (ramload),
    .ramstate    (rs),
    .arb_timeout (arb_timeout)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: who owns the port, the rotation pointer, flush set.
  bit           mvalid = 1'b0;
  bit           m_busy = 1'b0;
  bit           m_to   = 1'b0;
  bit           m_halt = 1'b0;
  bit           m_found;
  int           m_own  = 0;
  int           m_ptr  = 0;
  int           m_xcnt = 0;
  int           c;
  bit [N-1:0]   m_done = '0;
  logic         e_ren, e_wen;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_store;
  logic [N-1:0]  e_wait;

  initial begin
    forever begin
      @(negedge clk);
      if (mvalid) begin
        e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0; e_wait = '1;
        if (m_busy) begin
          e_wen   = wen[m_own];
          e_ren   = !wen[m_own];
          e_addr  = addr[m_own];
          e_store = store[m_own];
          if ((ren[m_own] || wen[m_own]) && rs == RS_ACCESS) e_wait[m_own] = 1'b0;
        end
        chk("model_ramREN", 64'(ram_ren), 64'(e_ren));
        chk("model_ramWEN", 64'(ram_wen), 64'(e_wen));
        chk("model_ramaddr", 64'(ramaddr), 64'(e_addr));
        chk("model_ramstore", 64'(ramstore), 64'(e_store));
        chk("model_req_wait", 64'(req_wait), 64'(e_wait));
        chk("model_req_load", 64'(req_load), 64'(ramload));
        chk("model_halt", 64'(halt), 64'(m_halt));
        chk("model_timeout", 64'(arb_timeout), 64'(m_to));
      end
      if (rst) begin
        mvalid = 1'b1; m_busy = 1'b0; m_to = 1'b0; m_halt = 1'b0;
        m_own = 0; m_ptr = 0; m_xcnt = 0; m_done = '0;
      end else begin
        if (!m_busy) begin
          m_found = 1'b0;
          for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (!m_found && (ren[c] || wen[c])) begin
              m_found = 1'b1;
              m_own   = c;
            end
          end
          if (m_found) begin
            m_busy = 1'b1;
            m_xcnt = 0;
          end
        end else if (!(ren[m_own] || wen[m_own])) begin
          m_busy = 1'b0;
        end else if (rs == RS_ACCESS) begin
          m_busy = 1'b0;
          m_ptr  = (m_own + 1) % N;
        end else begin
          m_xcnt++;
          if (WDOG && m_xcnt == WD) begin
            m_to   = 1'b1;
            m_busy = 1'b0;
            m_ptr  = (m_own + 1) % N;
          end
        end
        m_done = m_done | flushed;
        m_halt = &m_done;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  int            order [5] = '{0, 1, 2, 3, 0};
  logic [N-1:0]  ew;

  initial begin
    for (int i = 0; i < N; i++) begin
      addr[i]  = '0;
      store[i] = '0;
    end
    tick(); tick();
    rst = 1'b0;
    #2;
    chk("reset_ramREN", 64'(ram_ren), 64'd0);
    chk("reset_ramWEN", 64'(ram_wen), 64'd0);
    chk("reset_ramaddr", 64'(ramaddr), 64'd0);
    chk("reset_req_wait", 64'(req_wait), 64'hF);
    chk("reset_halt", 64'(halt), 64'd0);
    chk("reset_timeout", 64'(arb_timeout), 64'd0);

    // Core 0 single read, best-case latency.
    ren[0] = 1'b1; addr[0] = 32'h40;
    tick();
    rs = RS_ACCESS; ramload = 32'h1234_5678;
    #2;
    chk("rd0_ramREN", 64'(ram_ren), 64'd1);
    chk("rd0_ramaddr", 64'(ramaddr), 64'h40);
    chk("rd0_wait", 64'(req_wait), 64'hE);
    chk("rd0_load", 64'(req_load), 64'h1234_5678);
    tick();
    // Pointer now at 1: core 1 wins over core 0.
    rs = RS_FREE; ren[1] = 1'b1; addr[1] = 32'h100;
    tick();
    #2;
    chk("rot_ramaddr", 64'(ramaddr), 64'h100);
    rs = RS_ACCESS;
    #1;
    chk("rot_wait", 64'(req_wait), 64'hD);
    tick();
    ren[1] = 1'b0; rs = RS_FREE;
    #2;
    chk("bubble_ramREN", 64'(ram_ren), 64'd0);
    tick();
    #2;
    chk("rot2_ramaddr", 64'(ramaddr), 64'h40);
    rs = RS_ACCESS;
    tick();
    ren = '0; rs = RS_FREE;

    // All four requesting, one BUSY cycle per grant.
    for (int i = 0; i < N; i++) addr[i] = 32'h1000 + 32'(i) * 32'h10;
    ren = 4'hF;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int g = 0; g < 5; g++) begin
      rs = RS_FREE;
      #2;
      chk("rr_bubble", 64'(ram_ren), 64'd0);
      tick();
      rs = RS_BUSY;
      #2;
      chk("rr_busy_wait", 64'(req_wait), 64'hF);
      tick();
      rs = RS_ACCESS;
      #2;
      chk("rr_grant_order", 64'(ramaddr), 64'h1000 + 64'(order[g]) * 64'h10);
      ew = 4'hF; ew[order[g]] = 1'b0;
      chk("rr_grant_wait", 64'(req_wait), 64'(ew));
      tick();
    end
    ren = '0; rs = RS_FREE;

    // Core 2 read and write together: write wins.
    ren[2] = 1'b1; wen[2] = 1'b1; addr[2] = 32'h80; store[2] = 32'hDEAD_BEEF; rs = RS_BUSY;
    tick();
    #2;
    chk("wr_ramWEN", 64'(ram_wen), 64'd1);
    chk("wr_ramREN", 64'(ram_ren), 64'd0);
    chk("wr_ramstore", 64'(ramstore), 64'hDEAD_BEEF);
    chk("wr_ramaddr", 64'(ramaddr), 64'h80);
    rs = RS_ACCESS;
    tick();
    ren = '0; wen = '0; rs = RS_FREE;

    // Reset in the middle of core 1's BUSY transfer.
    for (int i = 0; i < N; i++) addr[i] = 32'h100 * 32'(i);
    addr[0] = 32'h40;
    ren[1] = 1'b1;
    tick();
    rs = RS_BUSY;
    #2;
    chk("mid_ramREN", 64'(ram_ren), 64'd1);
    chk("mid_ramaddr", 64'(ramaddr), 64'h100);
    rst = 1'b1;
    tick();
    rst = 1'b0; ren[0] = 1'b1;
    #2;
    chk("rst_ramREN", 64'(ram_ren), 64'd0);
    chk("rst_ramWEN", 64'(ram_wen), 64'd0);
    chk("rst_wait", 64'(req_wait), 64'hF);
    tick();
    #2;
    chk("rst_first_grant", 64'(ramaddr), 64'h40);
    rs = RS_ACCESS;
    tick();
    ren = '0; rs = RS_FREE;

    // Core 3 aborts mid-transfer; pointer must stay at 1.
    ren[3] = 1'b1;
    tick();
    rs = RS_BUSY;
    tick();
    ren[3] = 1'b0; rs = RS_ACCESS;
    #2;
    chk("abort_wait", 64'(req_wait), 64'hF);
    tick();
    ren[1] = 1'b1; ren[3] = 1'b1; rs = RS_FREE;
    tick();
    #2;
    chk("abort_next_grant", 64'(ramaddr), 64'h100);
    rs = RS_ACCESS;
    tick();
    ren = '0; rs = RS_FREE;

    // Flush pulses 0, 2, 1, 3.
    flushed = 4'b0001; #2; chk("halt_f0", 64'(halt), 64'd0); tick();
    flushed = 4'b0100; #2; chk("halt_f2", 64'(halt), 64'd0); tick();
    flushed = 4'b0010; #2; chk("halt_f1", 64'(halt), 64'd0); tick();
    flushed = 4'b1000; #2; chk("halt_f3", 64'(halt), 64'd0); tick();
    flushed = 4'b0000; #2; chk("halt_rise", 64'(halt), 64'd1); tick();
    #2; chk("halt_sticky", 64'(halt), 64'd1);

    // Long BUSY hold on core 0 (pointer at 2 here).
    ren[0] = 1'b1; rs = RS_BUSY;
    tick();
`ifdef MC_ARB_WATCHDOG_EN
    for (int k = 0; k < WD; k++) begin
      #2;
      chk("wd_pending", 64'(arb_timeout), 64'd0);
      tick();
    end
    ren[1] = 1'b1;
    #2;
    chk("wd_timeout", 64'(arb_timeout), 64'd1);
    chk("wd_idle", 64'(ram_ren), 64'd0);
    tick();
    #2;
    chk("wd_next_grant", 64'(ramaddr), 64'h100);
`else
    for (int k = 0; k < WD + 4; k++) begin
      #2;
      chk("hold_ramREN", 64'(ram_ren), 64'd1);
      chk("hold_no_timeout", 64'(arb_timeout), 64'd0);
      tick();
    end
`endif
    rs = RS_ACCESS;
    tick();
    ren = '0; rs = RS_FREE;
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
